// File: rtl/aurora_pkg.sv
// Shared definitions for the Aurora lane link manager.
//   state_e  : 3-bit link FSM encoding (also exported on state_o)
//   sat_inc  : saturating +1 on a counter of up to SAT_W bits
package aurora_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PMA     = 3'd1,
    ST_RSTPB   = 3'd2,
    ST_WAIT_UP = 3'd3,
    ST_LINKED  = 3'd4,
    ST_RETRAIN = 3'd5
  } state_e;

  localparam int SAT_W = 32;

  // v is treated as a w-bit counter zero-extended to SAT_W. For w=SAT_W the
  // shift yields 0, and 0-1 is already the all-ones mask.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                               input int unsigned w);
    logic [SAT_W-1:0] ones;
    ones = (SAT_W'(1) << w) - SAT_W'(1);
    return (v == ones) ? v : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/aurora_lane_link_mgr_if.sv
// Link manager signal bundle.
//   master : host/Aurora side (drives control and core status, reads results)
//   slave  : link manager (reads control and core status, drives core resets and status)
interface aurora_lane_link_mgr_if #(
  parameter int NUM_LANES = 4,
  parameter int CNT_W     = 16
);
  logic                 enable;
  logic                 clr_cnt;
  logic [NUM_LANES-1:0] lane_up;
  logic                 channel_up;
  logic                 hard_err;
  logic                 soft_err;
  logic                 pma_init;
  logic                 reset_pb;
  logic [NUM_LANES-1:0] lane_stable;
  logic                 link_ok;
  logic [2:0]           state_o;
  logic [CNT_W-1:0]     retrain_cnt;
  logic [CNT_W-1:0]     soft_err_cnt;

  modport master (
    output enable, clr_cnt, lane_up, channel_up, hard_err, soft_err,
    input  pma_init, reset_pb, lane_stable, link_ok, state_o, retrain_cnt, soft_err_cnt
  );

  modport slave (
    input  enable, clr_cnt, lane_up, channel_up, hard_err, soft_err,
    output pma_init, reset_pb, lane_stable, link_ok, state_o, retrain_cnt, soft_err_cnt
  );
endinterface

// File: rtl/aurora_lane_debounce.sv
// One-lane lane_up debouncer.
//   ap_clk/ap_rst_n : clock, async active-low reset
//   clr             : hold counter and flag at 0 (core logic in reset)
//   in              : raw lane_up
//   stable          : set after DEBOUNCE_CYC consecutive high cycles; drops on the
//                     edge after in goes low (no fall hysteresis)
module aurora_lane_debounce #(
  parameter int DEBOUNCE_CYC = 256
)(
  input  logic ap_clk,
  input  logic ap_rst_n,
  input  logic clr,
  input  logic in,
  output logic stable
);
  localparam int CW = $clog2(DEBOUNCE_CYC);

  logic [CW-1:0] cnt;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (clr || !in) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
      stable <= 1'b1;                // count parks at terminal value
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/aurora_lane_link_mgr.sv
// Aurora N-lane link manager: pma_init/reset_pb bring-up sequencing, per-lane
// lane_up debounce, link_ok qualification, auto-retrain on loss/hard error,
// saturating retrain and soft-error counters.
//   ap_clk/ap_rst_n : clock, async active-low reset
//   bus (slave)     : enable, clr_cnt, lane_up, channel_up, hard_err, soft_err in;
//                     pma_init, reset_pb, lane_stable, link_ok, state_o,
//                     retrain_cnt, soft_err_cnt out
module aurora_lane_link_mgr
  import aurora_pkg::*;
#(
  parameter int NUM_LANES        = 4,
  parameter int CNT_W            = 16,
  parameter int DEBOUNCE_CYC     = 256,
  parameter int PMA_INIT_CYC     = 1024,
  parameter int RESET_PB_CYC     = 128,
  parameter int LINK_TIMEOUT_CYC = 2**20
)(
  input logic                    ap_clk,
  input logic                    ap_rst_n,
  aurora_lane_link_mgr_if.slave  bus
);
  localparam int MAX_A   = (PMA_INIT_CYC > RESET_PB_CYC) ? PMA_INIT_CYC : RESET_PB_CYC;
  localparam int MAX_DUR = (MAX_A > LINK_TIMEOUT_CYC) ? MAX_A : LINK_TIMEOUT_CYC;
  localparam int TMR_W   = $clog2(MAX_DUR);

  state_e               state, nxt;
  logic [TMR_W-1:0]     timer;
  logic                 pma_q, rpb_q, link_q;
  logic [CNT_W-1:0]     retr_q, soft_q;
  logic [NUM_LANES-1:0] stable;

  // Debounce is held in reset together with the core logic (reset_pb).
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    aurora_lane_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .clr      (rpb_q),
      .in       (bus.lane_up[i]),
      .stable   (stable[i])
    );
  end

  // In LINKED all lanes were stable on entry, so any cleared bit is a fall.
  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:    if (bus.enable) nxt = ST_PMA;
      ST_PMA:     if (timer == TMR_W'(PMA_INIT_CYC - 1)) nxt = ST_RSTPB;
      ST_RSTPB:   if (timer == TMR_W'(RESET_PB_CYC - 1)) nxt = ST_WAIT_UP;
      ST_WAIT_UP: if (&stable && bus.channel_up)         nxt = ST_LINKED;
                  else if (timer == TMR_W'(LINK_TIMEOUT_CYC - 1)) nxt = ST_RETRAIN;
      ST_LINKED:  if (bus.hard_err || !bus.channel_up || !(&stable)) nxt = ST_RETRAIN;
      ST_RETRAIN: nxt = ST_PMA;
      default:    nxt = ST_IDLE;
    endcase
    if (!bus.enable) nxt = ST_IDLE;
  end

  // Outputs are decoded from the next state so they change with state_o.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state  <= ST_IDLE;
      timer  <= '0;
      pma_q  <= 1'b1;
      rpb_q  <= 1'b1;
      link_q <= 1'b0;
      retr_q <= '0;
      soft_q <= '0;
    end else begin
      state  <= nxt;
      timer  <= (nxt != state) ? '0 : timer + TMR_W'(1);
      pma_q  <= nxt inside {ST_IDLE, ST_PMA, ST_RETRAIN};
      rpb_q  <= nxt inside {ST_IDLE, ST_PMA, ST_RSTPB, ST_RETRAIN};
      link_q <= (nxt == ST_LINKED);
      if (nxt == ST_RETRAIN)
        retr_q <= CNT_W'(sat_inc(SAT_W'(retr_q), CNT_W));
      if (state == ST_LINKED && bus.soft_err)
        soft_q <= CNT_W'(sat_inc(SAT_W'(soft_q), CNT_W));
      if (bus.clr_cnt) begin
        retr_q <= '0;
        soft_q <= '0;
      end
    end
  end

  assign bus.pma_init     = pma_q;
  assign bus.reset_pb     = rpb_q;
  assign bus.link_ok      = link_q;
  assign bus.state_o      = state;
  assign bus.lane_stable  = stable;
  assign bus.retrain_cnt  = retr_q;
  assign bus.soft_err_cnt = soft_q;
endmodule

// File: tb/tb_aurora_lane_link_mgr.sv
// Randomised + directed bench for aurora_lane_link_mgr against a cycle-level
// reference model built from lane run-lengths and time-in-state.
module tb_aurora_lane_link_mgr;
  localparam int NL = 4, CW = 4, DB = 8, PMA = 16, RPB = 4, TMO = 200;
  localparam int CMAX = (1 << CW) - 1;

  logic ap_clk, ap_rst_n;
  aurora_lane_link_mgr_if #(.NUM_LANES(NL), .CNT_W(CW)) bus ();

  aurora_lane_link_mgr #(
    .NUM_LANES(NL), .CNT_W(CW), .DEBOUNCE_CYC(DB), .PMA_INIT_CYC(PMA),
    .RESET_PB_CYC(RPB), .LINK_TIMEOUT_CYC(TMO)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus.slave)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---- reference model ----
  int m_st, m_age, m_retr, m_soft;
  int m_run [NL];   // consecutive qualifying lane_up-high cycles, capped at DB

  function automatic void model_reset();
    m_st = 0; m_age = 0; m_retr = 0; m_soft = 0;
    foreach (m_run[i]) m_run[i] = 0;
  endfunction

  function automatic bit all_stable();
    foreach (m_run[i]) if (m_run[i] < DB) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_step();
    bit core_rst = (m_st == 0 || m_st == 1 || m_st == 2 || m_st == 5);
    bit st_all   = all_stable();
    int nx       = m_st;
    case (m_st)
      0: if (bus.enable) nx = 1;
      1: if (m_age + 1 == PMA) nx = 2;
      2: if (m_age + 1 == RPB) nx = 3;
      3: if (st_all && bus.channel_up) nx = 4;
         else if (m_age + 1 == TMO) nx = 5;
      4: if (bus.hard_err || !bus.channel_up || !st_all) nx = 5;
      5: nx = 1;
      default: nx = 0;
    endcase
    if (!bus.enable) nx = 0;
    if (nx == 5 && m_retr < CMAX) m_retr++;
    if (m_st == 4 && bus.soft_err && m_soft < CMAX) m_soft++;
    if (bus.clr_cnt) begin m_retr = 0; m_soft = 0; end
    for (int i = 0; i < NL; i++)
      if (core_rst || !bus.lane_up[i]) m_run[i] = 0;
      else if (m_run[i] < DB) m_run[i]++;
    m_age = (nx != m_st) ? 0 : m_age + 1;
    m_st  = nx;
  endfunction

  function automatic logic [NL-1:0] exp_stable();
    logic [NL-1:0] s;
    for (int i = 0; i < NL; i++) s[i] = (m_run[i] >= DB);
    return s;
  endfunction

  task automatic cmp_all();
    chk("state_o",      bus.state_o, m_st);
    chk("pma_init",     bus.pma_init, (m_st == 0 || m_st == 1 || m_st == 5));
    chk("reset_pb",     bus.reset_pb, (m_st == 0 || m_st == 1 || m_st == 2 || m_st == 5));
    chk("link_ok",      bus.link_ok, (m_st == 4));
    chk("lane_stable",  bus.lane_stable, exp_stable());
    chk("retrain_cnt",  bus.retrain_cnt, m_retr);
    chk("soft_err_cnt", bus.soft_err_cnt, m_soft);
  endtask

  task automatic tick();
    @(posedge ap_clk);
    if (!ap_rst_n) model_reset(); else model_step();
    #2;
    cmp_all();
  endtask

  task automatic run_until(input int st, input int budget, input string tag);
    int n = 0;
    while (m_st != st && n < budget) begin tick(); n++; end
    chk(tag, bus.state_o, st);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pma"},  bus.pma_init, 1);
    chk({tag, "_rpb"},  bus.reset_pb, 1);
    chk({tag, "_stb"},  bus.lane_stable, 0);
    chk({tag, "_link"}, bus.link_ok, 0);
    chk({tag, "_st"},   bus.state_o, 0);
    chk({tag, "_retr"}, bus.retrain_cnt, 0);
    chk({tag, "_soft"}, bus.soft_err_cnt, 0);
  endtask

  initial begin
    int n1, n2, n3, r;
    logic seen;
    bus.enable = 0; bus.clr_cnt = 0; bus.lane_up = '0; bus.channel_up = 0;
    bus.hard_err = 0; bus.soft_err = 0;
    model_reset();
    ap_rst_n = 1'b1;
    #1 ap_rst_n = 1'b0;
    #1 chk_reset_vals("rst");
    repeat (3) tick();
    ap_rst_n = 1'b1;

    // 1. bring-up with no lanes
    bus.enable = 1;
    n1 = 0; n2 = 0;
    repeat (30) begin
      tick();
      if (bus.state_o == 3'd1) n1++;
      if (bus.state_o == 3'd2) n2++;
    end
    chk("pma_len", n1, PMA);
    chk("rstpb_len", n2, RPB);
    chk("wait_up_st", bus.state_o, 3);

    // 2. link up
    bus.lane_up = '1; bus.channel_up = 1;
    repeat (DB - 1) tick();
    chk("stable_early", bus.lane_stable, 4'h0);
    tick();
    chk("stable_8", bus.lane_stable, 4'hF);
    chk("link_pre", bus.link_ok, 0);
    tick();
    chk("link_up", bus.link_ok, 1);
    chk("retr0", bus.retrain_cnt, 0);

    // 3. single-cycle lane glitch
    r = $urandom_range(NL - 1);
    bus.lane_up[r] = 1'b0;
    tick();
    chk("glitch_drop", bus.lane_stable[r], 0);
    bus.lane_up = '1;
    tick();
    chk("glitch_retr_st", bus.state_o, 5);
    chk("glitch_retr_cnt", bus.retrain_cnt, 1);
    tick();
    chk("glitch_pma", bus.pma_init, 1);
    // 5-cycle pulse in WAIT_UP
    bus.lane_up = '0;
    run_until(3, 40, "reach_wait");
    seen = 0;
    bus.lane_up = '1;
    repeat (5) begin tick(); if (bus.lane_stable != 0) seen = 1; end
    bus.lane_up = '0;
    repeat (5) begin tick(); if (bus.lane_stable != 0) seen = 1; end
    chk("short_pulse", seen, 0);

    // 4. timeout retrains, saturating counter
    bus.channel_up = 0;
    run_until(5, TMO + 10, "tmo_retrain");
    run_until(3, 40, "tmo_wait");
    n3 = 0;
    while (m_st == 3 && n3 < TMO + 10) begin tick(); if (bus.state_o == 3'd3) n3++; end
    chk("tmo_len", n3 + 1, TMO);   // entry cycle was observed before the loop
    n1 = 0;
    while (m_retr < CMAX && n1 < 20 * (TMO + PMA + RPB + 2)) begin tick(); n1++; end
    run_until(3, 40, "sat_wait");
    run_until(5, TMO + 10, "sat_retrain");
    chk("retr_sat", bus.retrain_cnt, CMAX);
    bus.clr_cnt = 1; tick(); bus.clr_cnt = 0;
    chk("retr_clr", bus.retrain_cnt, 0);

    // 5. error counting
    bus.lane_up = '1; bus.channel_up = 1;
    run_until(4, 80, "err_link");
    bus.soft_err = 1; repeat (10) tick(); bus.soft_err = 0;
    tick();
    chk("soft10", bus.soft_err_cnt, 10);
    bus.soft_err = 1; bus.clr_cnt = 1; tick(); bus.clr_cnt = 0; bus.soft_err = 0;
    chk("soft_clr_wins", bus.soft_err_cnt, 0);
    bus.soft_err = 1; repeat (CMAX + 5) tick(); bus.soft_err = 0;
    chk("soft_sat", bus.soft_err_cnt, CMAX);
    bus.hard_err = 1; tick(); bus.hard_err = 0;
    chk("hard_retr", bus.state_o, 5);

    // 6. enable override in RSTPB
    run_until(2, 40, "reach_rstpb");
    bus.enable = 0; tick();
    chk("ovr_st", bus.state_o, 0);
    chk("ovr_pma", bus.pma_init, 1);
    chk("ovr_rpb", bus.reset_pb, 1);
    bus.enable = 1;

    // random traffic
    repeat (3000) begin
      bus.enable     = ($urandom_range(299) != 0);
      bus.clr_cnt    = ($urandom_range(199) == 0);
      for (int i = 0; i < NL; i++) bus.lane_up[i] = ($urandom_range(63) != 0);
      bus.channel_up = ($urandom_range(31) != 0);
      bus.hard_err   = ($urandom_range(255) == 0);
      bus.soft_err   = ($urandom_range(3) == 0);
      tick();
    end

    // async reset while LINKED
    bus.enable = 1; bus.clr_cnt = 0; bus.lane_up = '1; bus.channel_up = 1;
    bus.hard_err = 0; bus.soft_err = 0;
    run_until(4, 400, "rst_link");
    #2 ap_rst_n = 1'b0;
    #1 chk_reset_vals("async");
    model_reset();
    repeat (2) tick();
    ap_rst_n = 1'b1;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
